wb_commit_queue: RTL and testbench

In-order dual-issue writeback buffer between the two execute/memory lanes and the dual-write-port register file. Accepts up to two results per cycle, holds them in program order, and drains up to two per cycle onto the register file write ports. Drives the port pair so that a same-destination pair always leaves the younger value in the register. Also reports per-read-address pending status for issue-stage hazard checks.

---
 rtl/wb_commit_queue.sv | 160 ++++++++++++++++
 tb/tb_wb_commit_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_queue.sv
// In-order dual-issue writeback buffer feeding a dual-write-port register file.
// Optional same-cycle bypass when empty: define WBQ_BYPASS_EN.
module wb_commit_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid0,
  input  logic                     in_valid1,
  input  logic [4:0]               in_rd0,
  input  logic [4:0]               in_rd1,
  input  logic [XLEN-1:0]          in_data0,
  input  logic [XLEN-1:0]          in_data1,
  input  logic                     in_we0,
  input  logic                     in_we1,
  output logic                     in_ready,
  input  logic                     drain_en,
  output logic [4:0]               rd1,
  output logic [XLEN-1:0]          wb_data1,
  output logic                     wb_we1,
  output logic [4:0]               rd2,
  output logic [XLEN-1:0]          wb_data2,
  output logic                     wb_we2,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [4:0]               rs3,
  input  logic [4:0]               rs4,
  output logic                     pend1,
  output logic                     pend2,
  output logic                     pend3,
  output logic                     pend4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;

  logic [4:0]      rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  ptr_t          head, tail;
  ptr_t          head_p1, tail_p1;
  logic [CW-1:0] count_q;

  logic       keep0, keep1;
  logic       bypass;
  logic       enq_en;
  logic [1:0] enq_n, deq_n;

  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;

  // Slots that do not write a real register never occupy an entry.
  assign keep0 = in_valid0 & in_we0 & (in_rd0 != 5'd0);
  assign keep1 = in_valid1 & in_we1 & (in_rd1 != 5'd0);

  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign count    = count_q;

`ifdef WBQ_BYPASS_EN
  assign bypass = drain_en & (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign enq_en = in_ready & ~bypass;
  assign enq_n  = enq_en ? ({1'b0, keep0} + {1'b0, keep1}) : 2'd0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    deq_n = 2'd0;
    if (drain_en) begin
      if (count_q >= CW'(2))      deq_n = 2'd2;
      else if (count_q == CW'(1)) deq_n = 2'd1;
    end
  end

  // Older entry on port 2, younger on port 1: the register file favours port 1.
  always_comb begin
    wb_we1   = 1'b0;
    wb_we2   = 1'b0;
    rd1      = '0;
    rd2      = '0;
    wb_data1 = '0;
    wb_data2 = '0;
    if (drain_en) begin
      if (bypass) begin
        if (keep0 && keep1) begin
          wb_we2 = 1'b1; rd2 = in_rd0; wb_data2 = in_data0;
          wb_we1 = 1'b1; rd1 = in_rd1; wb_data1 = in_data1;
        end else if (keep0) begin
          wb_we1 = 1'b1; rd1 = in_rd0; wb_data1 = in_data0;
        end else if (keep1) begin
          wb_we1 = 1'b1; rd1 = in_rd1; wb_data1 = in_data1;
        end
      end else if (count_q >= CW'(2)) begin
        wb_we2 = 1'b1; rd2 = rd_mem[head];    wb_data2 = data_mem[head];
        wb_we1 = 1'b1; rd1 = rd_mem[head_p1]; wb_data1 = data_mem[head_p1];
      end else if (count_q == CW'(1)) begin
        wb_we1 = 1'b1; rd1 = rd_mem[head];    wb_data1 = data_mem[head];
      end
    end
  end

  // An entry is live when its distance from head is below count.
  logic [4:0] rs_vec   [4];
  logic [3:0] pend_vec;

  assign rs_vec[0] = rs1;
  assign rs_vec[1] = rs2;
  assign rs_vec[2] = rs3;
  assign rs_vec[3] = rs4;

  always_comb begin
    pend_vec = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (({1'b0, ptr_t'(ptr_t'(i) - head)} < count_q) &&
            (rd_mem[i] == rs_vec[j]) && (rs_vec[j] != 5'd0))
          pend_vec[j] = 1'b1;
      end
    end
  end

  assign pend1 = pend_vec[0];
  assign pend2 = pend_vec[1];
  assign pend3 = pend_vec[2];
  assign pend4 = pend_vec[3];

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + ptr_t'(deq_n);
      tail    <= tail + ptr_t'(enq_n);
      count_q <= count_q + CW'(enq_n) - CW'(deq_n);
    end
  end

  // NOTE: the storage array has no reset; occupancy is defined solely by head/count.
  always_ff @(posedge clk) begin
    if (enq_en) begin
      if (keep0 || keep1) begin
        rd_mem[tail]   <= keep0 ? in_rd0   : in_rd1;
        data_mem[tail] <= keep0 ? in_data0 : in_data1;
      end
      if (keep0 && keep1) begin
        rd_mem[tail_p1]   <= in_rd1;
        data_mem[tail_p1] <= in_data1;
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue: queue-based reference model plus
// register-file models fed by the reference and by the DUT write ports.
module tb_wb_commit_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid0, in_valid1, in_we0, in_we1;
  logic [4:0]      in_rd0, in_rd1;
  logic [XLEN-1:0] in_data0, in_data1;
  logic            in_ready, drain_en;
  logic [4:0]      rd1, rd2;
  logic [XLEN-1:0] wb_data1, wb_data2;
  logic            wb_we1, wb_we2;
  logic [4:0]      rs1, rs2, rs3, rs4;
  logic            pend1, pend2, pend3, pend4;
  logic [CW-1:0]   count;

  wb_commit_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_rd0(in_rd0), .in_rd1(in_rd1),
    .in_data0(in_data0), .in_data1(in_data1),
    .in_we0(in_we0), .in_we1(in_we1),
    .in_ready(in_ready), .drain_en(drain_en),
    .rd1(rd1), .wb_data1(wb_data1), .wb_we1(wb_we1),
    .rd2(rd2), .wb_data2(wb_data2), .wb_we2(wb_we2),
    .rs1(rs1), .rs2(rs2), .rs3(rs3), .rs4(rs4),
    .pend1(pend1), .pend2(pend2), .pend3(pend3), .pend4(pend4),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            q[$];
  logic [XLEN-1:0] exp_rf [32];
  logic [XLEN-1:0] dut_rf [32];
  int              checks = 0;
  int              errors = 0;

  function automatic logic model_pend(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    in_valid0 = 0; in_valid1 = 0; in_we0 = 0; in_we1 = 0;
    in_rd0 = 0; in_rd1 = 0; in_data0 = 0; in_data1 = 0;
  endtask

  task automatic set_pair(input logic [4:0] r0, input logic [XLEN-1:0] d0,
                          input logic [4:0] r1, input logic [XLEN-1:0] d1);
    in_valid0 = 1; in_we0 = 1; in_rd0 = r0; in_data0 = d0;
    in_valid1 = 1; in_we1 = 1; in_rd1 = r1; in_data1 = d1;
  endtask

  // One clock: predict from the model, compare at negedge, advance at posedge.
  task automatic cycle();
    ent_t kept[$];
    ent_t p1, p2;
    bit   ready, byp, e_we1, e_we2;
    int   npop;
    kept = {};
    if (in_valid0 && in_we0 && in_rd0 != 0) kept.push_back('{in_rd0, in_data0});
    if (in_valid1 && in_we1 && in_rd1 != 0) kept.push_back('{in_rd1, in_data1});
    ready = (DEPTH - q.size()) >= 2;
    byp = 0;
`ifdef WBQ_BYPASS_EN
    byp = drain_en && (q.size() == 0);
`endif
    e_we1 = 0; e_we2 = 0; p1 = '{0, 0}; p2 = '{0, 0};
    if (drain_en) begin
      if (byp) begin
        if (kept.size() == 2) begin e_we2 = 1; p2 = kept[0]; e_we1 = 1; p1 = kept[1]; end
        else if (kept.size() == 1) begin e_we1 = 1; p1 = kept[0]; end
      end else if (q.size() >= 2) begin
        e_we2 = 1; p2 = q[0]; e_we1 = 1; p1 = q[1];
      end else if (q.size() == 1) begin
        e_we1 = 1; p1 = q[0];
      end
    end
    @(negedge clk);
    checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL count: got %0d expected %0d", count, q.size()); end
    checks++; if (in_ready !== ready) begin errors++; $display("FAIL in_ready: got %b expected %b", in_ready, ready); end
    checks++; if (wb_we1 !== e_we1) begin errors++; $display("FAIL wb_we1: got %b expected %b", wb_we1, e_we1); end
    checks++; if (wb_we2 !== e_we2) begin errors++; $display("FAIL wb_we2: got %b expected %b", wb_we2, e_we2); end
    if (e_we1) begin
      checks++; if (rd1 !== p1.rd || wb_data1 !== p1.data) begin errors++;
        $display("FAIL port1: got rd=%0d data=%h expected rd=%0d data=%h", rd1, wb_data1, p1.rd, p1.data); end
    end
    if (e_we2) begin
      checks++; if (rd2 !== p2.rd || wb_data2 !== p2.data) begin errors++;
        $display("FAIL port2: got rd=%0d data=%h expected rd=%0d data=%h", rd2, wb_data2, p2.rd, p2.data); end
    end
    checks++; if ({pend1, pend2, pend3, pend4} !== {model_pend(rs1), model_pend(rs2), model_pend(rs3), model_pend(rs4)}) begin
      errors++; $display("FAIL pend: got %b%b%b%b expected %b%b%b%b", pend1, pend2, pend3, pend4,
        model_pend(rs1), model_pend(rs2), model_pend(rs3), model_pend(rs4)); end
    // Register-file write at the coming edge: port 1 applied last so it wins.
    if (wb_we2 === 1'b1) dut_rf[rd2] = wb_data2;
    if (wb_we1 === 1'b1) dut_rf[rd1] = wb_data1;
    if (e_we2) exp_rf[p2.rd] = p2.data;
    if (e_we1) exp_rf[p1.rd] = p1.data;
    if (!byp) begin
      npop = int'(e_we1) + int'(e_we2);
      repeat (npop) void'(q.pop_front());
    end
    if (ready && !byp) foreach (kept[i]) q.push_back(kept[i]);
    @(posedge clk); #1;
  endtask

  task automatic flush();
    idle_inputs(); drain_en = 1;
    repeat (DEPTH) cycle();
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); drain_en = 0; rs1 = 0; rs2 = 0; rs3 = 0; rs4 = 0;
    foreach (exp_rf[i]) begin exp_rf[i] = '0; dut_rf[i] = '0; end
    #12;
    checks++; if (count !== '0 || in_ready !== 1'b1 || wb_we1 !== 1'b0 || wb_we2 !== 1'b0) begin errors++;
      $display("FAIL reset_state: got count=%0d ready=%b we1=%b we2=%b expected 0 1 0 0", count, in_ready, wb_we1, wb_we2); end
    checks++; if ({pend1, pend2, pend3, pend4} !== 4'b0) begin errors++;
      $display("FAIL reset_pend: got %b%b%b%b expected 0000", pend1, pend2, pend3, pend4); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    idle_inputs(); drain_en = 1;
    in_valid0 = 1; in_we0 = 1; in_rd0 = 5'd3; in_data0 = 32'hAAAA5555;
    cycle();
    idle_inputs();
    cycle();
    checks++; if (dut_rf[3] !== 32'hAAAA5555) begin errors++; $display("FAIL single_x3: got %h expected aaaa5555", dut_rf[3]); end
  endtask

  task automatic test_waw();
    drain_en = 1;
    set_pair(5'd7, 32'd1, 5'd7, 32'd2);
    cycle();
    idle_inputs();
    cycle(); cycle();
    checks++; if (dut_rf[7] !== 32'd2) begin errors++; $display("FAIL waw_x7: got %0d expected 2", dut_rf[7]); end
  endtask

  task automatic test_filter();
    drain_en = 0;
    set_pair(5'd0, 32'h1111, 5'd9, 32'h9999);
    cycle();
    idle_inputs();
    checks++; if (count !== CW'(1)) begin errors++; $display("FAIL filter_count: got %0d expected 1", count); end
    in_valid0 = 1; in_we0 = 0; in_rd0 = 5'd4; in_data0 = 32'h4444;
    cycle();
    idle_inputs(); drain_en = 1;
    cycle(); cycle();
    checks++; if (dut_rf[9] !== 32'h9999 || dut_rf[4] !== 32'h0) begin errors++;
      $display("FAIL filter_rf: got x9=%h x4=%h expected x9=9999 x4=0", dut_rf[9], dut_rf[4]); end
  endtask

  task automatic test_full_wrap();
    drain_en = 0;
    for (int i = 0; i < 4; i++) begin
      set_pair(5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(1, 31)), $urandom);
      cycle();
    end
    idle_inputs();
    checks++; if (count !== CW'(8) || in_ready !== 1'b0) begin errors++;
      $display("FAIL full: got count=%0d ready=%b expected 8 0", count, in_ready); end
    set_pair(5'd5, 32'hDEAD, 5'd6, 32'hBEEF);
    cycle();
    drain_en = 1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      set_pair(5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(1, 31)), $urandom);
      cycle();
    end
    flush();
    checks++; if (count !== '0) begin errors++; $display("FAIL wrap_drained: got %0d expected 0", count); end
  endtask

  task automatic test_pending();
    idle_inputs(); drain_en = 0; rs1 = 0; rs2 = 5'd13; rs3 = 5'd12; rs4 = 5'd12;
    in_valid0 = 1; in_we0 = 1; in_rd0 = 5'd12; in_data0 = 32'hC0C0;
    cycle();
    idle_inputs();
    cycle();
    checks++; if (pend3 !== 1'b1 || pend1 !== 1'b0 || pend2 !== 1'b0) begin errors++;
      $display("FAIL pend_queued: got p1=%b p2=%b p3=%b expected 0 0 1", pend1, pend2, pend3); end
    drain_en = 1;
    cycle();
    cycle();
    checks++; if (pend3 !== 1'b0) begin errors++; $display("FAIL pend_cleared: got %b expected 0", pend3); end
    rs2 = 0; rs3 = 0; rs4 = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid0 = ($urandom_range(0, 3) != 0); in_we0 = ($urandom_range(0, 7) != 0);
      in_valid1 = ($urandom_range(0, 3) != 0); in_we1 = ($urandom_range(0, 7) != 0);
      in_rd0 = 5'($urandom_range(0, 31)); in_rd1 = 5'($urandom_range(0, 31));
      in_data0 = $urandom; in_data1 = $urandom;
      drain_en = ($urandom_range(0, 3) != 0);
      rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
      rs3 = 5'($urandom_range(0, 31)); rs4 = 5'($urandom_range(0, 31));
      cycle();
    end
    flush();
    foreach (exp_rf[r]) begin
      checks++; if (dut_rf[r] !== exp_rf[r]) begin errors++;
        $display("FAIL rf_x%0d: got %h expected %h", r, dut_rf[r], exp_rf[r]); end
    end
  endtask

  task automatic test_reset_midstream();
    drain_en = 0;
    set_pair(5'd1, 32'h11, 5'd2, 32'h22); cycle();
    set_pair(5'd3, 32'h33, 5'd4, 32'h44); cycle();
    set_pair(5'd0, 32'h00, 5'd5, 32'h55); cycle();
    idle_inputs();
    checks++; if (count !== CW'(5)) begin errors++; $display("FAIL pre_reset_count: got %0d expected 5", count); end
    drain_en = 1;
    #1; rst = 1; #1;
    checks++; if (count !== '0 || wb_we1 !== 1'b0 || wb_we2 !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL async_reset: got count=%0d we1=%b we2=%b ready=%b expected 0 0 0 1", count, wb_we1, wb_we2, in_ready); end
    q.delete();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_waw();
    test_filter();
    test_full_wrap();
    test_pending();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
